muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit holding the HI/LO register pair.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the core and the multiply/divide unit.
// The core drives requests (master); the unit returns status and HI/LO (slave).
interface muldiv_unit_if #(
   parameter int unsigned DATA_W = 32
) ();
   logic              iStart;
   logic [2:0]        iOp;
   logic [DATA_W-1:0] iA;
   logic [DATA_W-1:0] iB;
   logic              iFlush;
   logic              oBusy;
   logic              oDone;
   logic              oDivByZero;
   logic [DATA_W-1:0] oHI;
   logic [DATA_W-1:0] oLO;

   modport master (
      output iStart, iOp, iA, iB, iFlush,
      input  oBusy, oDone, oDivByZero, oHI, oLO
   );

   modport slave (
      input  iStart, iOp, iA, iB, iFlush,
      output oBusy, oDone, oDivByZero, oHI, oLO
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: one bit per cycle shift-add multiply
// and restoring divide on operand magnitudes, with sign correction in a final FIX cycle.
module muldiv_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   muldiv_unit_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic                r_busy;
   logic                r_done;
   logic                r_dbz;
   logic                r_is_div;
   logic                r_neg_q;
   logic                r_neg_r;
   logic                r_div0;
   logic [DATA_W-1:0]   r_a_orig;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_mq;
   logic [DATA_W-1:0]   r_b;

   logic                w_signed;
   logic                w_is_div;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [DATA_W-1:0]   w_a_mag;
   logic [DATA_W-1:0]   w_b_mag;
   logic [DATA_W:0]     w_madd;
   logic [DATA_W:0]     w_shift;
   logic                w_ge;
   logic [DATA_W-1:0]   w_diff;
   logic [2*DATA_W-1:0] w_prod;
   logic [2*DATA_W-1:0] w_prod_fix;
   logic [DATA_W-1:0]   w_quo;
   logic [DATA_W-1:0]   w_rem;

   // Even op codes are the signed variants; bit 1 selects divide.
   assign w_signed = ~bus.iOp[0];
   assign w_is_div = bus.iOp[1];
   assign w_a_neg  = w_signed & bus.iA[DATA_W-1];
   assign w_b_neg  = w_signed & bus.iB[DATA_W-1];
   assign w_a_mag  = w_a_neg ? -bus.iA : bus.iA;
   assign w_b_mag  = w_b_neg ? -bus.iB : bus.iB;

   // Multiply: {acc, mq} shifts right, adding the multiplicand into acc when mq[0] is set.
   assign w_madd = r_mq[0] ? ({1'b0, r_acc} + {1'b0, r_b}) : {1'b0, r_acc};

   // Divide: partial remainder in acc, dividend shifts out of mq while quotient bits shift in.
   assign w_shift = {r_acc, r_mq[DATA_W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_b});
   assign w_diff  = w_shift[DATA_W-1:0] - r_b;

   assign w_prod     = {r_acc, r_mq};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo      = r_neg_q ? -r_mq : r_mq;
   assign w_rem      = r_neg_r ? -r_acc : r_acc;

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_a_orig <= '0;
         r_acc    <= '0;
         r_mq     <= '0;
         r_b      <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (bus.iStart && !bus.iFlush) begin
                  case (bus.iOp)
                     3'b100: r_hi <= bus.iA;
                     3'b101: r_lo <= bus.iA;
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= w_is_div && (bus.iB == '0);
                        r_a_orig <= bus.iA;
                        r_acc    <= '0;
                        r_b      <= w_is_div ? w_b_mag : w_a_mag;
                        r_mq     <= w_is_div ? w_a_mag : w_b_mag;
                        r_cnt    <= CNT_W'(DATA_W);
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_state  <= StRun;
                     end
                     default: ;
                  endcase
               end
            end
            StRun: begin
               if (bus.iFlush) begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else begin
                  if (r_is_div) begin
                     r_acc <= w_ge ? w_diff : w_shift[DATA_W-1:0];
                     r_mq  <= {r_mq[DATA_W-2:0], w_ge};
                  end else begin
                     r_acc <= w_madd[DATA_W:1];
                     r_mq  <= {w_madd[0], r_mq[DATA_W-1:1]};
                  end
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_state <= StFix;
                  end
               end
            end
            StFix: begin
               if (!bus.iFlush) begin
                  if (!r_is_div) begin
                     r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                     r_lo <= w_prod_fix[DATA_W-1:0];
                  end else if (r_div0) begin
                     r_hi <= r_a_orig;
                     r_lo <= '1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end
                  r_done <= 1'b1;
                  r_dbz  <= r_is_div && r_div0;
               end
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.oBusy      = r_busy;
   assign bus.oDone      = r_done;
   assign bus.oDivByZero = r_dbz;
   assign bus.oHI        = r_hi;
   assign bus.oLO        = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at DATA_W=32 with hand-computed HI/LO, latency and flags.
module tb_muldiv_unit;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;

   muldiv_unit_if #(.DATA_W(32)) bus ();

   muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .iCLK  (clk),
      .iRSTn (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
      $fatal(1);
   end

   // Issues a MULT/DIV request and waits (bounded) for oDone; lat=0 means it never came.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc, output logic dz, output logic dz_acc);
      bus.iStart = 1'b1;
      bus.iOp    = op;
      bus.iA     = a;
      bus.iB     = b;
      @(posedge clk); #1;
      bus.iStart = 1'b0;
      dz_acc = bus.oDivByZero;
      bcyc = bus.oBusy ? 1 : 0;
      lat  = 0;
      dz   = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (bus.oDone) begin
            lat = k;
            dz  = bus.oDivByZero;
            break;
         end
         if (bus.oBusy) bcyc++;
      end
   endtask

   task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
      bus.iStart = 1'b1;
      bus.iOp    = op;
      bus.iA     = a;
      @(posedge clk); #1;
      bus.iStart = 1'b0;
   endtask

   task automatic test_reset();
      bus.iStart = 1'b0; bus.iOp = 3'b000; bus.iA = '0; bus.iB = '0; bus.iFlush = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'h0) begin
         n_miss++; $display("FAIL reset_hilo: got %h_%h need 0_0", bus.oHI, bus.oLO);
      end
      n_vec++;
      if ({bus.oBusy, bus.oDone, bus.oDivByZero} !== 3'b000) begin
         n_miss++;
         $display("FAIL reset_flags: got %b need 000", {bus.oBusy, bus.oDone, bus.oDivByZero});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      int lat; int bcyc; logic dz; logic dza;
      do_op(3'b000, 32'hFFFF_FFFD, 32'd7, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         n_miss++; $display("FAIL mult_neg3x7: got %h_%h need ffffffff_ffffffeb", bus.oHI, bus.oLO);
      end
      n_vec++;
      if (lat !== 33) begin
         n_miss++; $display("FAIL mult_latency: got %0d need 33", lat);
      end
      n_vec++;
      if (bcyc !== 33) begin
         n_miss++; $display("FAIL mult_busy_cycles: got %0d need 33", bcyc);
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.oDone !== 1'b0) begin
         n_miss++; $display("FAIL done_pulse_width: got %b need 0", bus.oDone);
      end
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'hFFFF_FFFE_0000_0001) begin
         n_miss++; $display("FAIL multu_max: got %h_%h need fffffffe_00000001", bus.oHI, bus.oLO);
      end
      do_op(3'b000, 32'h8000_0000, 32'h8000_0000, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'h4000_0000_0000_0000) begin
         n_miss++; $display("FAIL mult_minxmin: got %h_%h need 40000000_00000000", bus.oHI, bus.oLO);
      end
   endtask

   task automatic test_div();
      int lat; int bcyc; logic dz; logic dza;
      do_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         n_miss++; $display("FAIL div_neg7_2: got hi=%h lo=%h need ffffffff fffffffd", bus.oHI, bus.oLO);
      end
      do_op(3'b010, 32'd7, 32'hFFFF_FFFE, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'h0000_0001_FFFF_FFFD) begin
         n_miss++; $display("FAIL div_7_neg2: got hi=%h lo=%h need 00000001 fffffffd", bus.oHI, bus.oLO);
      end
      do_op(3'b011, 32'hFFFF_FFFF, 32'h10, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO} !== 64'h0000_000F_0FFF_FFFF) begin
         n_miss++; $display("FAIL divu_max_16: got hi=%h lo=%h need 0000000f 0fffffff", bus.oHI, bus.oLO);
      end
      do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO, dz} !== {64'h0000_0000_8000_0000, 1'b0}) begin
         n_miss++;
         $display("FAIL div_min_neg1: got hi=%h lo=%h dz=%b need 0 80000000 0", bus.oHI, bus.oLO, dz);
      end
      n_vec++;
      if (lat !== 33) begin
         n_miss++; $display("FAIL div_latency: got %0d need 33", lat);
      end
   endtask

   task automatic test_div_zero();
      int lat; int bcyc; logic dz; logic dza;
      do_op(3'b010, 32'd5, 32'd0, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO, dz, lat} !== {64'h0000_0005_FFFF_FFFF, 1'b1, 32'd33}) begin
         n_miss++;
         $display("FAIL div_by_zero: got hi=%h lo=%h dz=%b lat=%0d need 5 ffffffff 1 33",
                  bus.oHI, bus.oLO, dz, lat);
      end
      do_op(3'b011, 32'd10, 32'd3, lat, bcyc, dz, dza);
      n_vec++;
      if (dza !== 1'b0) begin
         n_miss++; $display("FAIL dbz_clear_on_accept: got %b need 0", dza);
      end
      n_vec++;
      if ({bus.oHI, bus.oLO, dz} !== {64'h0000_0001_0000_0003, 1'b0}) begin
         n_miss++; $display("FAIL divu_10_3: got hi=%h lo=%h dz=%b need 1 3 0", bus.oHI, bus.oLO, dz);
      end
      do_op(3'b010, 32'hFFFF_FFFB, 32'd0, lat, bcyc, dz, dza);
      n_vec++;
      if ({bus.oHI, bus.oLO, dz} !== {64'hFFFF_FFFB_FFFF_FFFF, 1'b1}) begin
         n_miss++;
         $display("FAIL div_neg_by_zero: got hi=%h lo=%h dz=%b need fffffffb ffffffff 1",
                  bus.oHI, bus.oLO, dz);
      end
   endtask

   task automatic test_hold();
      int ndone;
      do_mt(3'b100, 32'h1234);
      do_mt(3'b101, 32'h1234);
      n_vec++;
      if ({bus.oHI, bus.oLO, bus.oBusy, bus.oDone} !== {64'h0000_1234_0000_1234, 2'b00}) begin
         n_miss++;
         $display("FAIL mthi_mtlo: got hi=%h lo=%h busy=%b done=%b need 1234 1234 0 0",
                  bus.oHI, bus.oLO, bus.oBusy, bus.oDone);
      end
      bus.iB = 32'd5;
      do_mt(3'b001, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.oHI, bus.oLO, bus.oBusy} !== {64'h0000_1234_0000_1234, 1'b1}) begin
         n_miss++;
         $display("FAIL hold_during_run: got hi=%h lo=%h busy=%b need 1234 1234 1",
                  bus.oHI, bus.oLO, bus.oBusy);
      end
      do_mt(3'b101, 32'hDEAD);
      n_vec++;
      if (bus.oLO !== 32'h1234) begin
         n_miss++; $display("FAIL mtlo_while_busy: got %h need 00001234", bus.oLO);
      end
      ndone = 0;
      for (int k = 0; k < 40 && ndone == 0; k++) begin
         @(posedge clk); #1;
         if (bus.oDone) ndone++;
      end
      n_vec++;
      if ({ndone, bus.oHI, bus.oLO} !== {32'd1, 64'h0000_0000_0000_000F}) begin
         n_miss++;
         $display("FAIL multu_3x5_after_mt: got done=%0d hi=%h lo=%h need 1 0 f",
                  ndone, bus.oHI, bus.oLO);
      end
   endtask

   task automatic test_flush();
      int ndone; int lat; int bcyc; logic dz; logic dza;
      do_mt(3'b100, 32'h1234);
      do_mt(3'b101, 32'h1234);
      bus.iFlush = 1'b1;
      do_mt(3'b001, 32'd3);
      bus.iFlush = 1'b0;
      n_vec++;
      if (bus.oBusy !== 1'b0) begin
         n_miss++; $display("FAIL start_with_flush: got busy=%b need 0", bus.oBusy);
      end
      bus.iB = 32'd5;
      do_mt(3'b001, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      bus.iFlush = 1'b1;
      @(posedge clk); #1;
      bus.iFlush = 1'b0;
      n_vec++;
      if (bus.oBusy !== 1'b0) begin
         n_miss++; $display("FAIL flush_busy: got %b need 0", bus.oBusy);
      end
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.oDone) ndone++;
      end
      n_vec++;
      if ({ndone, bus.oHI, bus.oLO} !== {32'd0, 64'h0000_1234_0000_1234}) begin
         n_miss++;
         $display("FAIL flush_no_done: got done=%0d hi=%h lo=%h need 0 1234 1234",
                  ndone, bus.oHI, bus.oLO);
      end
      do_mt(3'b001, 32'd3);
      repeat (2) @(posedge clk);
      #1;
      bus.iFlush = 1'b1;
      @(posedge clk); #1;
      bus.iFlush = 1'b0;
      do_op(3'b001, 32'd2, 32'd3, lat, bcyc, dz, dza);
      n_vec++;
      if ({lat, bus.oHI, bus.oLO} !== {32'd33, 64'h0000_0000_0000_0006}) begin
         n_miss++;
         $display("FAIL accept_after_flush: got lat=%0d hi=%h lo=%h need 33 0 6",
                  lat, bus.oHI, bus.oLO);
      end
   endtask

   task automatic test_async_reset();
      int lat; int bcyc; logic dz; logic dza;
      do_op(3'b010, 32'd9, 32'd0, lat, bcyc, dz, dza);
      do_mt(3'b100, 32'h1234);
      do_mt(3'b101, 32'h1234);
      bus.iB = 32'd5;
      do_mt(3'b001, 32'd3);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.oHI, bus.oLO, bus.oBusy, bus.oDone, bus.oDivByZero} !== 67'h0) begin
         n_miss++;
         $display("FAIL async_reset_midrun: got hi=%h lo=%h busy=%b done=%b dz=%b need all 0",
                  bus.oHI, bus.oLO, bus.oBusy, bus.oDone, bus.oDivByZero);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(3'b000, 32'd6, 32'hFFFF_FFF9, lat, bcyc, dz, dza);
      n_vec++;
      if ({lat, bus.oHI, bus.oLO} !== {32'd33, 64'hFFFF_FFFF_FFFF_FFD6}) begin
         n_miss++;
         $display("FAIL mult_after_reset: got lat=%0d hi=%h lo=%h need 33 ffffffff ffffffd6",
                  lat, bus.oHI, bus.oLO);
      end
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_hold();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
